weight_fetch_arbiter: RTL and testbench

//  Shares one external weight-memory read port between N_REQ linear-layer engines (final classifier stage).

---
 rtl/weight_arb_pkg.sv | 17 +
 rtl/weight_fetch_arbiter_rr_picker.sv | 37 +++
 rtl/weight_fetch_arbiter.sv | 150 +++++++++++++++
 tb/tb_weight_fetch_arbiter.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/weight_arb_pkg.sv
// Shared types and helpers for the weight fetch arbiter.
//   arb_state_t : arbiter FSM states
//   gid_w()     : grant-id width for N requesters, never below 1 bit
//   STAT_W      : per-engine grant counter width (statistics build)
//   WAIT_STAT_W : longest-wait statistic width (statistics build)
package weight_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} arb_state_t;

  localparam int STAT_W      = 32;
  localparam int WAIT_STAT_W = 16;

  function automatic int gid_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/weight_fetch_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick.
// Returns the first set bit of req at or after ptr, wrapping N-1 -> 0.
//   req   : request vector
//   ptr   : round-robin start index (always < N)
//   found : some request is set
//   idx   : chosen index (0 when nothing is set)
module rr_picker
  import weight_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]          req,
  input  logic [gid_w(N)-1:0]   ptr,
  output logic                  found,
  output logic [gid_w(N)-1:0]   idx
);

  localparam int IW = gid_w(N);

  logic [IW-1:0] j;

  // Walk offsets from farthest to nearest so the nearest hit is the last
  // assignment and therefore wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    j     = '0;
    for (int o = N - 1; o >= 0; o--) begin
      j = IW'((int'(ptr) + o) % N);
      if (req[j]) begin
        found = 1'b1;
        idx   = j;
      end
    end
  end

endmodule

// File: rtl/weight_fetch_arbiter.sv
// weight_fetch_arbiter: shares one weight-memory read port between N_REQ
// engines. Round-robin grant, one outstanding read, data broadcast, valid
// pulsed one-hot to the granted engine.
// Optional feature macro: WEIGHT_ARB_STATS_EN (adds stat_grants, stat_wait_max).
// Ports:
//   clk, rst              clock, async active-high reset
//   req, req_addr         per-engine level request and address
//   rsp_data, rsp_valid   broadcast data, one-hot one-cycle valid
//   mem_rd_en, mem_addr   read strobe and held address to weight memory
//   mem_rdata, mem_rvalid memory return
//   busy                  FSM not in IDLE
//   grant_id              current / last granted engine
//   timeout_err           sticky read-timeout flag
//   stat_grants           (stats) per-engine RESPOND count, saturating
//   stat_wait_max         (stats) longest WAIT duration, saturating
module weight_fetch_arbiter
  import weight_arb_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 13,
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [N_REQ-1:0]               req,
  input  logic [N_REQ-1:0][ADDR_W-1:0]   req_addr,
  output logic signed [WIDTH-1:0]        rsp_data,
  output logic [N_REQ-1:0]               rsp_valid,
  output logic                           mem_rd_en,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic signed [WIDTH-1:0]        mem_rdata,
  input  logic                           mem_rvalid,
  output logic                           busy,
  output logic [gid_w(N_REQ)-1:0]        grant_id,
  output logic                           timeout_err
`ifdef WEIGHT_ARB_STATS_EN
  ,
  output logic [N_REQ-1:0][STAT_W-1:0]   stat_grants,
  output logic [WAIT_STAT_W-1:0]         stat_wait_max
`endif
);

  localparam int GW    = gid_w(N_REQ);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  // Counter is wide enough for both the timeout compare and the wait statistic.
  localparam int CNT_W = (WAIT_STAT_W > TO_W) ? WAIT_STAT_W : TO_W;

  arb_state_t       state;
  logic [GW-1:0]    rr_ptr;
  logic [GW-1:0]    pick_idx;
  logic [GW-1:0]    next_ptr;
  logic             pick_found;
  logic [CNT_W-1:0] wait_cnt;
  logic             wait_hit;
  logic             wait_abort;

  rr_picker #(.N(N_REQ)) u_pick (
    .req   (req),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign next_ptr = (int'(grant_id) >= N_REQ - 1) ? '0 : grant_id + 1'b1;

  // wait_cnt counts completed WAIT cycles; the TIMEOUT-th WAIT cycle aborts
  // unless data arrives in that same cycle.
  assign wait_hit   = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign wait_abort = (state == WAIT) && !mem_rvalid && wait_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      mem_addr    <= '0;
      mem_rd_en   <= 1'b0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else begin
      mem_rd_en <= 1'b0;
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            state     <= ISSUE;
            busy      <= 1'b1;
            grant_id  <= pick_idx;
            mem_addr  <= req_addr[pick_idx];
            mem_rd_en <= 1'b1;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end
        WAIT: begin
          if (mem_rvalid) begin
            rsp_data  <= mem_rdata;
            rsp_valid <= N_REQ'(1) << grant_id;
            state     <= RESPOND;
          end else if (wait_abort) begin
            // Requester keeps req high and is re-served in its turn.
            timeout_err <= 1'b1;
            rr_ptr      <= next_ptr;
            busy        <= 1'b0;
            state       <= IDLE;
          end else if (!(&wait_cnt)) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESPOND: begin
          rr_ptr <= next_ptr;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef WEIGHT_ARB_STATS_EN
  logic [CNT_W-1:0]       wait_len;
  logic [WAIT_STAT_W-1:0] wait_len_sat;

  // Duration of the WAIT phase ending this cycle (current cycle included).
  assign wait_len     = (&wait_cnt) ? wait_cnt : wait_cnt + 1'b1;
  assign wait_len_sat = (wait_len > CNT_W'({WAIT_STAT_W{1'b1}})) ? '1
                        : wait_len[WAIT_STAT_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_wait_max <= '0;
      stat_grants   <= '0;
    end else begin
      if (state == WAIT && (mem_rvalid || wait_abort) && wait_len_sat > stat_wait_max)
        stat_wait_max <= wait_len_sat;
      for (int i = 0; i < N_REQ; i++) begin
        if (state == RESPOND && int'(grant_id) == i && !(&stat_grants[i]))
          stat_grants[i] <= stat_grants[i] + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_weight_fetch_arbiter.sv
// Self-checking bench for weight_fetch_arbiter: transaction-level timeline
// model checked every cycle, directed scenarios with literal expectations,
// then randomized requests and memory latencies.
module tb_weight_fetch_arbiter;

  localparam int N  = 4;
  localparam int AW = 13;
  localparam int W  = 16;
  localparam int TO = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N-1:0][AW-1:0] req_addr;
  logic [W-1:0]      rsp_data;
  logic [N-1:0]      rsp_valid;
  logic              mem_rd_en;
  logic [AW-1:0]     mem_addr;
  logic [W-1:0]      mem_rdata;
  logic              mem_rvalid;
  logic              busy;
  logic [1:0]        grant_id;
  logic              timeout_err;
`ifdef WEIGHT_ARB_STATS_EN
  logic [N-1:0][31:0] stat_grants;
  logic [15:0]        stat_wait_max;
`endif

  weight_fetch_arbiter #(.WIDTH(W), .ADDR_W(AW), .N_REQ(N), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_addr    (req_addr),
    .rsp_data    (rsp_data),
    .rsp_valid   (rsp_valid),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .mem_rvalid  (mem_rvalid),
    .busy        (busy),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
`ifdef WEIGHT_ARB_STATS_EN
    ,
    .stat_grants   (stat_grants),
    .stat_wait_max (stat_wait_max)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_chk = 0, n_fail = 0, cyc = 0;

  // engines and memory
  logic [N-1:0]  e_req = '0, e_hold = '0, e_skip = '0;
  logic [AW-1:0] e_addr [N];
  bit            rnd_on = 0;
  int            force_lat = 1;   // -1 random, 0 never answer, else fixed
  int            mem_at = -1;
  logic [AW-1:0] mem_pend_addr = '0;

  // model state
  bit            m_act, m_done, m_err;
  int            m_a, m_rsp, m_end, m_g, m_ptr, m_wmax;
  int            m_cnt [N];
  logic [AW-1:0] m_addr;
  logic [W-1:0]  m_data;
  logic [N-1:0]  p_req;
  logic [AW-1:0] p_addr [N];
  bit            p_rv, p_busy;
  logic [W-1:0]  p_rdata;

  function automatic logic [W-1:0] mem_word(input logic [AW-1:0] a);
    return W'(a) ^ 16'h1231;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int ptr);
    for (int o = 0; o < N; o++)
      if (r[(ptr + o) % N]) return (ptr + o) % N;
    return -1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_done = 0; m_err = 0; m_a = -100; m_rsp = -1; m_end = -1;
    m_g = 0; m_ptr = 0; m_addr = '0; m_data = '0; m_wmax = 0;
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
  endtask

  task automatic model_and_check();
    if (rst) model_reset();
    else begin
      // outcome of the read, judged from the inputs of the previous cycle
      if (m_act && !m_done && cyc - 1 >= m_a + 1) begin
        if (p_rv) begin
          m_done = 1; m_rsp = cyc; m_end = cyc + 1; m_data = p_rdata;
          m_ptr = (m_g + 1) % N; m_cnt[m_g]++;
          if (cyc - 1 - m_a > m_wmax) m_wmax = cyc - 1 - m_a;
        end else if (cyc - 1 == m_a + TO) begin
          m_done = 1; m_end = cyc; m_err = 1; m_ptr = (m_g + 1) % N;
          if (TO > m_wmax) m_wmax = TO;
        end
      end
      if (m_act && cyc == m_end) m_act = 0;
      else if (!m_act && !p_busy && p_req != '0) begin
        m_g = pick(p_req, m_ptr); m_act = 1; m_done = 0; m_a = cyc;
        m_rsp = -1; m_end = 1 << 30; m_addr = p_addr[m_g];
      end
    end
    chk("busy",      busy,        m_act);
    chk("rd_en",     mem_rd_en,   m_act && cyc == m_a);
    chk("mem_addr",  mem_addr,    m_addr);
    chk("grant_id",  grant_id,    m_g);
    chk("rsp_valid", rsp_valid,   (cyc == m_rsp) ? (64'd1 << m_g) : 64'd0);
    chk("rsp_data",  rsp_data,    m_data);
    chk("timeout",   timeout_err, m_err);
  endtask

  task automatic latch_inputs();
    req = e_req;
    for (int i = 0; i < N; i++) begin
      req_addr[i] = e_addr[i];
      p_addr[i]   = e_addr[i];
    end
    p_req = e_req; p_rv = mem_rvalid; p_rdata = mem_rdata; p_busy = m_act;
  endtask

  task automatic react();
    int lat, r;
    if (mem_rd_en) begin
      if (force_lat < 0) begin
        r = $urandom_range(19);
        lat = (r < 14) ? 1 + r % 4 : (r < 17) ? TO : TO + 1;
      end else lat = force_lat;
      mem_at = (lat == 0) ? -1 : cyc + lat;
      mem_pend_addr = mem_addr;
    end
    mem_rvalid = (cyc == mem_at);
    mem_rdata  = (cyc == mem_at) ? mem_word(mem_pend_addr) : W'($urandom);
    for (int i = 0; i < N; i++) begin
      if (rsp_valid[i]) begin
        if (e_hold[i]) ;
        else if (e_skip[i]) e_skip[i] = 0;
        else e_req[i] = 0;
      end else if (rnd_on && !e_req[i] && $urandom_range(3) == 0) begin
        e_req[i] = 1; e_addr[i] = AW'($urandom); e_skip[i] = ($urandom_range(9) == 0);
      end
    end
    latch_inputs();
  endtask

  task automatic step();
    @(posedge clk); #1; cyc++;
    model_and_check();
    react();
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a);
    e_req[i] = 1; e_addr[i] = a; latch_inputs();
  endtask

  task automatic do_reset(input bit lit);
    rst = 1; e_req = '0; e_hold = '0; e_skip = '0; mem_at = -1; mem_rvalid = 0;
    latch_inputs();
    #1;
    if (lit) begin
      chk("rst_busy", busy, 0);       chk("rst_rd_en", mem_rd_en, 0);
      chk("rst_addr", mem_addr, 0);   chk("rst_gid", grant_id, 0);
      chk("rst_rspv", rsp_valid, 0);  chk("rst_data", rsp_data, 0);
      chk("rst_terr", timeout_err, 0);
    end
    step(); step();
    rst = 0;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while ((m_act || busy || e_req != '0) && n < 300) begin step(); n++; end
    if (n >= 300) begin
      n_chk++; n_fail++;
      $display("FAIL %s drain: still busy after %0d cycles", nm, n);
    end
  endtask

  initial begin
    int order[$];
    int n;
    for (int i = 0; i < N; i++) e_addr[i] = '0;
    mem_rvalid = 0; mem_rdata = '0;
    model_reset();
    latch_inputs();
    do_reset(0);
    chk("init_busy", busy, 0);
    chk("init_terr", timeout_err, 0);

    // 1: single engine, latency 1
    force_lat = 1; set_req(0, 13'h005);
    step(); chk("t1_strobe", mem_rd_en, 1); chk("t1_addr", mem_addr, 13'h005);
    step(); chk("t1_early", rsp_valid, 0);
    step(); chk("t1_rspv", rsp_valid, 4'b0001); chk("t1_data", rsp_data, 16'h1234);
    drain("t1");

    // 2: all engines hold req, grants rotate from 0
    do_reset(1);
    e_hold = '1;
    for (int i = 0; i < N; i++) set_req(i, AW'(16 + i));
    for (int s = 0; s < 22; s++) begin
      step();
      if (mem_rd_en) order.push_back(int'(grant_id));
    end
    chk("t2_ngrants", order.size() >= 5, 1);
    if (order.size() >= 5) begin
      chk("t2_g0", order[0], 0); chk("t2_g1", order[1], 1); chk("t2_g2", order[2], 2);
      chk("t2_g3", order[3], 3); chk("t2_g4", order[4], 0);
    end
    e_hold = '0; e_req = '0; latch_inputs();
    drain("t2");

    // 3: memory latency 7
    force_lat = 7; set_req(1, 13'h0AB);
    n = 0;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (mem_rd_en) n++;
      chk("t3_busy", busy, 1);
      if (j < 9) chk("t3_early", rsp_valid, 0);
      else chk("t3_rspv", rsp_valid, 4'b0010);
    end
    chk("t3_strobes", n, 1);
    drain("t3");

    // 4: engine 2 never answered -> abort after TO wait cycles, engine 3 next
    force_lat = 0; set_req(2, 13'h022); set_req(3, 13'h033);
    step(); chk("t4_gid", grant_id, 2); chk("t4_strobe", mem_rd_en, 1);
    force_lat = 1;
    for (int j = 2; j <= 10; j++) begin
      step();
      chk("t4_no_rsp", rsp_valid, 0);
      if (j == 9)  begin chk("t4_terr_pre", timeout_err, 0); chk("t4_busy", busy, 1); end
      if (j == 10) begin chk("t4_terr", timeout_err, 1); chk("t4_idle", busy, 0); end
    end
    step(); chk("t4_next_strobe", mem_rd_en, 1); chk("t4_next_gid", grant_id, 3);
    drain("t4");

    // 5: reset during WAIT, late data ignored, pointer back to 0
    force_lat = 0; set_req(0, 13'h044);
    step(); step(); step();
    chk("t5_in_wait", busy, 1);
    do_reset(1);
    mem_rvalid = 1; mem_rdata = 16'h7777; latch_inputs();
    step();
    chk("t5_late_rspv", rsp_valid, 0); chk("t5_late_busy", busy, 0); chk("t5_late_data", rsp_data, 0);
    force_lat = 1; set_req(0, 13'h050); set_req(3, 13'h053);
    step(); chk("t5_ptr0", grant_id, 0);
    drain("t5");

    // random traffic
    rnd_on = 1; force_lat = -1;
    repeat (1500) step();
    rnd_on = 0;
    drain("rand");

`ifdef WEIGHT_ARB_STATS_EN
    for (int i = 0; i < N; i++) chk("stat_rand", stat_grants[i], m_cnt[i]);
    chk("stat_wmax_rand", stat_wait_max, m_wmax);
    // 6: fixed grant counts after reset
    do_reset(0); force_lat = 1;
    for (int k = 0; k < 10; k++) begin set_req(1, AW'(k)); drain("t6a"); end
    for (int k = 0; k < 3; k++)  begin set_req(0, AW'(k)); drain("t6b"); end
    chk("t6_e1", stat_grants[1], 10); chk("t6_e0", stat_grants[0], 3);
    chk("t6_wmax", stat_wait_max, 1);
    for (int i = 0; i < N; i++) chk("stat_model", stat_grants[i], m_cnt[i]);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
